// File: rtl/sha256_top.sv
// sha256_top: single-block SHA-256 compression core with a digest / PUF output selector.
// Ports: clk; rst (synchronous, active-low); init/next start pulses; sel (1 = digest, 0 = pufout);
//   block (pre-padded 512 bits, W0 in [511:480]); ready; digest_valid; digest/pufout (H0 in [255:224]).
// Build option: define SHA_DUAL_ROUND_EN for two rounds per cycle (34-cycle latency instead of 66).
module sha256_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         next,
  input  logic         sel,
  input  logic [511:0] block,
  output logic         ready,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic [255:0] pufout
);

`ifdef SHA_DUAL_ROUND_EN
  localparam int RPC = 2;  // rounds per ROUNDS cycle
`else
  localparam int RPC = 1;
`endif
  localparam logic [6:0] LAST_CNT = 7'(64 / RPC);

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Next schedule word W[t+16] from W[t+14], W[t+9], W[t+1], W[t].
  function automatic logic [31:0] sched(input logic [31:0] w14, input logic [31:0] w9,
                                        input logic [31:0] w1, input logic [31:0] w0);
    logic [31:0] s0, s1;
    s0 = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
    s1 = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
    return s1 + w9 + s0 + w0;
  endfunction

  // One compression round; s = {a,b,c,d,e,f,g,h}, wk = W[t] + K[t].
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] wk);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + wk;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  state_t            state;
  logic [6:0]        cnt;
  logic [255:0]      h_reg;
  logic [255:0]      work;
  logic [255:0]      work_rnd;
  logic [255:0]      h_sum;
  logic [31:0]       w     [16];  // w[0] is the next schedule word to be consumed
  logic [31:0]       w_nxt [16];
  logic [32*RPC-1:0] wk;          // W+K registered one cycle ahead of its round
  logic [32*RPC-1:0] wk_nxt;

  // The W+K sum is pipelined: the first ROUNDS cycle (cnt = 0) only primes wk,
  // rounds execute for cnt = 1..LAST_CNT. This is the "load" cycle of the latency.
  always_comb begin
    for (int i = 0; i < 16 - RPC; i++) w_nxt[i] = w[i + RPC];
    w_nxt[16 - RPC] = sched(w[14], w[9], w[1], w[0]);
`ifdef SHA_DUAL_ROUND_EN
    w_nxt[15] = sched(w[15], w[10], w[2], w[1]);
    wk_nxt    = {w[0] + K[{cnt[4:0], 1'b0}], w[1] + K[{cnt[4:0], 1'b1}]};
    work_rnd  = sha_round(sha_round(work, wk[63:32]), wk[31:0]);
`else
    wk_nxt    = w[0] + K[cnt[5:0]];
    work_rnd  = sha_round(work, wk);
`endif
    h_sum = add8(h_reg, work);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      h_reg        <= '0;
      ready        <= 1'b1;
      digest_valid <= 1'b0;
      digest       <= '0;
      pufout       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init || next) begin
            if (init) begin
              h_reg <= IV;
              work  <= IV;
            end else begin
              work  <= h_reg;
            end
            for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
            cnt          <= '0;
            ready        <= 1'b0;
            digest_valid <= 1'b0;
            state        <= ROUNDS;
          end
        end
        ROUNDS: begin
          w  <= w_nxt;
          wk <= wk_nxt;
          if (cnt != 7'd0) work <= work_rnd;
          if (cnt == LAST_CNT) state <= DONE;
          else                 cnt   <= cnt + 7'd1;
        end
        DONE: begin
          h_reg <= h_sum;
          if (sel) digest <= h_sum;
          else     pufout <= h_sum;
          digest_valid <= 1'b1;
          ready        <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_top.sv
// tb_sha256_top: scoreboard bench for sha256_top (known-answer vectors, chaining, routing,
//   busy-pulse rejection, init/next priority, digest_valid lifetime, reset mid-operation).
module tb_sha256_top;

`ifdef SHA_DUAL_ROUND_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 66;
`endif

  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  // 56-byte message: the 0x80 pad byte fits in block 1, the bit length (448) lands in block 2.
  localparam logic [511:0] BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK2 = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         next;
  logic         sel;
  logic [511:0] block;
  logic         ready;
  logic         digest_valid;
  logic [255:0] digest;
  logic [255:0] pufout;

  sha256_top dut (
    .clk(clk), .rst(rst), .init(init), .next(next), .sel(sel), .block(block),
    .ready(ready), .digest_valid(digest_valid), .digest(digest), .pufout(pufout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [255:0] exp;
    logic         route;  // sel at job time
    logic         chk;    // 0: result not checked (intermediate chaining state)
  } sb_t;

  sb_t  sb[$];
  logic dv_q = 1'b0;

  // Scoreboard: every rising digest_valid retires the oldest accepted job.
  always @(negedge clk) begin
    if (digest_valid && !dv_q) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.chk) check(e.route ? "sb_digest" : "sb_pufout", e.route ? digest : pufout, e.exp);
      end
    end
    dv_q <= digest_valid;
  end

  // Drive one job; returns just after the capture edge.
  task automatic start(input logic i, input logic n, input logic [511:0] b,
                       input logic chk_en, input logic [255:0] exp);
    sb_t e;
    @(negedge clk);
    check("ready_idle", ready, 1);
    init  = i;
    next  = n;
    block = b;
    e.exp = exp; e.route = sel; e.chk = chk_en;
    sb.push_back(e);
    @(posedge clk);
    #1;
    init  = 1'b0;
    next  = 1'b0;
    block = ~b;
  endtask

  // Counts capture-relative cycles until digest_valid is seen; bounded.
  task automatic wait_done(input int start_n, output int n);
    n = start_n;
    while (n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (digest_valid) break;
    end
    if (!digest_valid) check("done_timeout", 0, 1);
  endtask

  initial begin
    int  n;
    bit  ok;
    rst = 1'b0; init = 1'b0; next = 1'b0; sel = 1'b1; block = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_dv", digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_pufout", pufout, 0);
    rst = 1'b1;

    // PUF routing: result only on pufout, digest untouched
    sel = 1'b0;
    start(1, 0, ABC_BLK, 1, ABC_DIG);
    wait_done(0, n);
    check("lat_puf", n, LAT);
    check("puf_digest_zero", digest, 0);

    // Signing path; pufout keeps the earlier result
    sel = 1'b1;
    start(1, 0, ABC_BLK, 1, ABC_DIG);
    wait_done(0, n);
    check("lat_abc", n, LAT);
    check("pufout_held", pufout, ABC_DIG);

    // Two-block chaining
    start(1, 0, BLK1, 0, '0);
    wait_done(0, n);
    start(0, 1, BLK2, 1, TWO_DIG);
    wait_done(0, n);
    check("lat_next", n, LAT);

    // Busy protocol: next and init pulses during ROUNDS are ignored
    start(1, 0, ABC_BLK, 1, ABC_DIG);
    n = 0;
    repeat (10) begin @(posedge clk); n++; end
    @(negedge clk); next = 1'b1; block = BLK2;
    @(posedge clk); n++; #1; next = 1'b0;
    repeat (5) begin @(posedge clk); n++; end
    @(negedge clk); init = 1'b1; block = BLK1;
    check("busy_ready", ready, 0);
    @(posedge clk); n++; #1; init = 1'b0;
    wait_done(n, n);
    check("lat_busy", n, LAT);

    // init and next together: init wins (H currently holds the "abc" digest)
    start(1, 1, ABC_BLK, 1, ABC_DIG);
    wait_done(0, n);

    // digest_valid lifetime
    ok = 1'b1;
    repeat (100) begin @(negedge clk); if (!digest_valid) ok = 1'b0; end
    check("dv_hold", ok, 1);
    start(1, 0, ABC_BLK, 1, ABC_DIG);
    @(negedge clk);
    check("dv_drop", digest_valid, 0);
    check("busy_after_accept", ready, 0);
    wait_done(1, n);

    // Reset around round 30 of a running job
    start(1, 0, ABC_BLK, 1, ABC_DIG);
    repeat (31) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_dv", digest_valid, 0);
    check("mid_rst_digest", digest, 0);
    check("mid_rst_pufout", pufout, 0);
    rst = 1'b1;
    sb.delete();
    ok = 1'b1;
    repeat (80) begin @(negedge clk); if (digest_valid) ok = 1'b0; end
    check("aborted_no_dv", ok, 1);
    start(1, 0, ABC_BLK, 1, ABC_DIG);
    wait_done(0, n);
    check("lat_rerun", n, LAT);

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
